conv_engine_stream: RTL and testbench

//  Parametrised, sequential linear-convolution engine: y[k] = sum_i a[i]*b[k-i], k = 0..La+Lb-2.

---
 rtl/conv_engine_stream.sv | 167 ++++++++++++++++
 tb/tb_conv_engine_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_engine_stream.sv
// Sequential linear convolution y[k] = sum a[i]*b[k-i]; samples and results stream over valid/ready.
// Latency: first result 2 cycles after the final load beat; each output k costs (terms_k + 1) cycles.
// Backpressure: in_ready only in LOAD; a result is held stable in OUT until out_ready, nothing dropped.
module conv_engine_stream #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int ACC_W   = 2 * DATA_W + $clog2(MAX_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len_a,
  input  logic [LEN_W-1:0]         len_b,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     err
);

  // k runs to 2*MAX_LEN-2; i shares the same width so the index arithmetic never wraps early
  localparam int KW = $clog2(2 * MAX_LEN + 1);
  localparam int CW = LEN_W + 1;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_OUT} state_t;

  state_t                    state_q, state_d;
  logic [LEN_W-1:0]          la_q, la_d, lb_q, lb_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [KW-1:0]             k_q, k_d, i_q, i_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      err_q, err_d;

  logic signed [DATA_W-1:0]  a_mem [MAX_LEN];
  logic signed [DATA_W-1:0]  b_mem [MAX_LEN];

  logic                      len_ok, beat;
  logic [CW-1:0]             total, b_off;
  logic [KW-1:0]             la_k, lb_k, k_inc, k_inc2, lo_cur, hi_cur, lo_next, last_k, bi;
  logic signed [DATA_W-1:0]  a_sel, b_sel;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;

  assign len_ok = (len_a != '0) && (len_a <= LEN_W'(MAX_LEN)) &&
                  (len_b != '0) && (len_b <= LEN_W'(MAX_LEN));
  assign beat   = (state_q == S_LOAD) && in_valid;
  assign total  = CW'(la_q) + CW'(lb_q);
  assign b_off  = cnt_q - CW'(la_q);

  // Term window for output k: lo = max(0, k-Lb+1), hi = min(k, La-1); computed from k+1 to stay unsigned
  assign la_k    = KW'(la_q);
  assign lb_k    = KW'(lb_q);
  assign k_inc   = k_q + KW'(1);
  assign k_inc2  = k_q + KW'(2);
  assign lo_cur  = (k_inc >= lb_k) ? (k_inc - lb_k) : '0;
  assign hi_cur  = (k_inc < la_k) ? k_q : (la_k - KW'(1));
  assign lo_next = (k_inc2 >= lb_k) ? (k_inc2 - lb_k) : '0;
  assign last_k  = la_k + lb_k - KW'(2);
  assign bi      = k_q - i_q;

  assign a_sel    = a_mem[i_q[IW-1:0]];
  assign b_sel    = b_mem[bi[IW-1:0]];
  assign prod     = a_sel * b_sel;
  assign prod_ext = ACC_W'(prod);

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_OUT);
  assign out_last  = (state_q == S_OUT) && (k_q == last_k);
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign out_data  = acc_q;

  // Sample buffers: written only on load beats, never reset (always reloaded before being read)
  always_ff @(posedge clk) begin
    if (beat && !rst) begin
      if (cnt_q < CW'(la_q)) a_mem[cnt_q[IW-1:0]] <= in_data;
      else                   b_mem[b_off[IW-1:0]] <= in_data;
    end
  end

  // Next-state and datapath decisions for the IDLE/LOAD/MAC/OUT sequence
  always_comb begin
    state_d = state_q;
    la_d    = la_q;
    lb_d    = lb_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    i_d     = i_q;
    acc_d   = acc_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            la_d    = len_a;
            lb_d    = len_b;
            cnt_d   = '0;
            k_d     = '0;
            i_d     = '0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (cnt_q == total - CW'(1)) begin
            k_d     = '0;
            i_d     = '0;
            state_d = S_MAC;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_MAC: begin
        // first term of each output restarts the sum instead of adding to the previous result
        acc_d = ((i_q == lo_cur) ? '0 : acc_q) + prod_ext;
        if (i_q == hi_cur) state_d = S_OUT;
        else               i_d = i_q + KW'(1);
      end
      S_OUT: begin
        if (out_ready) begin
          if (k_q == last_k) begin
            state_d = S_IDLE;
          end else begin
            k_d     = k_inc;
            i_d     = lo_next;
            state_d = S_MAC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      la_q    <= '0;
      lb_q    <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      i_q     <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_conv_engine_stream.sv
// Bench for conv_engine_stream: table of convolution runs with hand-computed results plus corner sequences.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Every wait on the DUT is bounded by a cycle budget.
module tb_conv_engine_stream;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 19;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [3:0]              len_a, len_b;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_last;
  logic                    busy;
  logic                    err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0]        la;
    logic [31:0]        lb;
    logic [7:0][31:0]   a;
    logic [7:0][31:0]   b;
    logic [14:0][31:0]  y;
  } vec_t;

  vec_t vt [6];

  conv_engine_stream dut (
    .clk(clk), .rst(rst), .start(start), .len_a(len_a), .len_b(len_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    int d;
    d = out_data;
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_out_data"}, d, 0);
  endtask

  task automatic feed(input vec_t v, input bit gaps);
    int la, lb, s;
    la = v.la;
    lb = v.lb;
    start = 1'b1; len_a = la[3:0]; len_b = lb[3:0];
    tick();
    start = 1'b0; len_a = '0; len_b = '0;
    for (int n = 0; n < la + lb; n++) begin
      if (gaps && (n % 2 == 1)) begin
        in_valid = 1'b0; in_data = 8'h55;
        tick();
      end
      s = (n < la) ? v.a[n] : v.b[n - la];
      in_valid = 1'b1; in_data = s[7:0];
      if (n == 0) check("in_ready_load", int'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input int vi, input int stall_k, input int stall_n, input bit gaps);
    vec_t v;
    int nout, w, d, e;
    v = vt[vi];
    nout = int'(v.la) + int'(v.lb) - 1;
    feed(v, gaps);
    check("in_ready_drop", int'(in_ready), 0);
    check("lat_mac", int'(out_valid), 0);
    tick();
    check("lat_out", int'(out_valid), 1);
    for (int k = 0; k < nout; k++) begin
      w = 0;
      while (!out_valid && w < 64) begin
        tick();
        w++;
      end
      if (!out_valid) begin
        check("out_valid_timeout", int'(out_valid), 1);
        return;
      end
      d = out_data;
      e = v.y[k];
      check($sformatf("v%0d_y%0d", vi, k), d, e);
      check($sformatf("v%0d_last%0d", vi, k), int'(out_last), (k == nout - 1) ? 1 : 0);
      if (k == stall_k) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          d = out_data;
          check("stall_valid", int'(out_valid), 1);
          check("stall_data", d, e);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    check($sformatf("v%0d_busy_end", vi), int'(busy), 0);
    check($sformatf("v%0d_valid_end", vi), int'(out_valid), 0);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) vt[i] = '0;
    // 3x2 ramp against box filter
    vt[0].la = 3; vt[0].lb = 2;
    vt[0].a[0] = 1; vt[0].a[1] = 2; vt[0].a[2] = 3;
    vt[0].b[0] = 1; vt[0].b[1] = 1;
    vt[0].y[0] = 1; vt[0].y[1] = 3; vt[0].y[2] = 5; vt[0].y[3] = 3;
    // 8x8 all -128: triangle scaled by 16384
    vt[1].la = 8; vt[1].lb = 8;
    for (int i = 0; i < 8; i++) begin
      vt[1].a[i] = -128;
      vt[1].b[i] = -128;
    end
    for (int k = 0; k < 15; k++) vt[1].y[k] = 16384 * ((k < 8) ? (k + 1) : (15 - k));
    // 1x1 single product
    vt[2].la = 1; vt[2].lb = 1;
    vt[2].a[0] = -3; vt[2].b[0] = 5; vt[2].y[0] = -15;
    // 1x3 scaling of b
    vt[3].la = 1; vt[3].lb = 3;
    vt[3].a[0] = 2; vt[3].b[0] = -1; vt[3].b[1] = 4; vt[3].b[2] = 7;
    vt[3].y[0] = -2; vt[3].y[1] = 8; vt[3].y[2] = 14;
    // 8x1 negation of a ramp
    vt[4].la = 8; vt[4].lb = 1;
    for (int i = 0; i < 8; i++) begin
      vt[4].a[i] = i + 1;
      vt[4].y[i] = -(i + 1);
    end
    vt[4].b[0] = -1;
    // 2x2 extreme values
    vt[5].la = 2; vt[5].lb = 2;
    vt[5].a[0] = 127; vt[5].a[1] = -128; vt[5].b[0] = -128; vt[5].b[1] = 127;
    vt[5].y[0] = -16256; vt[5].y[1] = 32513; vt[5].y[2] = -16256;

    rst = 1'b1; start = 1'b0; len_a = '0; len_b = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) tick();
    check_idle_zero("reset");
    rst = 1'b0;

    run_vec(0, -1, 0, 1'b0);
    run_vec(0, 1, 5, 1'b0);
    run_vec(1, -1, 0, 1'b0);
    run_vec(2, -1, 0, 1'b1);
    run_vec(3, -1, 0, 1'b0);
    run_vec(4, 7, 2, 1'b1);
    run_vec(5, -1, 0, 1'b0);

    // illegal lengths: one-cycle err pulse, engine stays idle
    start = 1'b1; len_a = 4'd0; len_b = 4'd3;
    tick();
    start = 1'b0;
    check("err_lena0", int'(err), 1);
    check("err_lena0_busy", int'(busy), 0);
    check("err_lena0_rdy", int'(in_ready), 0);
    tick();
    check("err_lena0_clear", int'(err), 0);
    start = 1'b1; len_a = 4'd3; len_b = 4'd9;
    tick();
    start = 1'b0;
    check("err_lenb9", int'(err), 1);
    check("err_lenb9_busy", int'(busy), 0);
    check("err_lenb9_rdy", int'(in_ready), 0);
    tick();
    check("err_lenb9_clear", int'(err), 0);
    check("err_lenb9_busy2", int'(busy), 0);

    // reset in the middle of the MAC phase of an 8x8 run
    feed(vt[1], 1'b0);
    repeat (6) tick();
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    check_idle_zero("midrst");
    rst = 1'b0;
    run_vec(0, -1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
